// File: rtl/acc_feeder_pkg.sv
// Purpose: shared defaults, widths and the frame-state type for the accumulator frame feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_W / FIFO_DEPTH defaults, frame counter width, RUN/GAP state enum,
//           and a helper that sizes the beat counter for any frame length.
package acc_feeder_pkg;

  localparam int DATA_W_DEFAULT     = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int FRAME_CNT_W        = 16;

  // RUN issues samples; GAP is the single idle cycle inserted after every frame.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_GAP = 1'b1
  } feeder_state_e;

  // A frame of one sample still needs a 1-bit counter so the vector is legal.
  function automatic int beat_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/acc_feeder_fifo.sv
// Purpose: small synchronous sample buffer; head word is always visible from registered storage.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: full is raised at DEPTH entries; pushes while full or during flush are dropped.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   flush                 synchronous empty; overrides any same-edge push and pop
//   push_vld / push_dat   write request and data
//   pop                   consume the head word (ignored when empty)
//   head_dat              oldest stored word
//   level                 number of stored words (0..DEPTH)
//   full                  level == DEPTH
module acc_feeder_fifo
  import acc_feeder_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int DEPTH  = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign push_ok = push_vld && !full && !flush;
  assign pop_ok  = pop && (level_q != '0) && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset: a word is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  assign head_dat = mem[rd_ptr];
  assign level    = level_q;

endmodule

// File: rtl/acc_frame_feeder.sv
// Purpose: buffers upstream samples and feeds an accumulator in frames of FRAME_LEN beats,
//          inserting one idle GAP cycle (carrying o_FRAME_DONE) after each frame.
// Latency: 2 edges from acceptance into an empty buffer to o_ENABLE high.
// Backpressure: o_READY is low when the buffer is full or in reset; i_HOLD stalls issue only.
// Ports:
//   i_CLK, i_RESET_N            clock, asynchronous active-low reset
//   i_VALID/o_READY/i_DATA_IN   upstream sample handshake
//   i_HOLD                      downstream stall, no sample issued while high
//   i_CLEAR                     synchronous flush of buffer and partial frame
//   o_ENABLE/o_DATA_OUT         registered accumulator drive
//   o_FRAME_DONE                one-cycle pulse in the GAP cycle after a frame's last beat
//   o_FRAME_COUNT               completed frames, wrapping at 16 bits
//   o_FIFO_LEVEL                buffered sample count
module acc_frame_feeder
  import acc_feeder_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEFAULT,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter  int FRAME_LEN  = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET_N,
  input  logic                   i_VALID,
  output logic                   o_READY,
  input  logic [DATA_W-1:0]      i_DATA_IN,
  input  logic                   i_HOLD,
  input  logic                   i_CLEAR,
  output logic                   o_ENABLE,
  output logic [DATA_W-1:0]      o_DATA_OUT,
  output logic                   o_FRAME_DONE,
  output logic [FRAME_CNT_W-1:0] o_FRAME_COUNT,
  output logic [LVL_W-1:0]       o_FIFO_LEVEL
);

  localparam int                BEAT_W    = beat_width(FRAME_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  feeder_state_e          state_q;
  feeder_state_e          state_d;
  logic [BEAT_W-1:0]      beat_q;
  logic                   pop;
  logic                   last_pop;
  logic                   gap_done;
  logic                   push_vld;
  logic                   fifo_full;
  logic [DATA_W-1:0]      head_dat;
  logic [LVL_W-1:0]       level;
  logic                   enable_q;
  logic [DATA_W-1:0]      data_q;
  logic                   frame_done_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;

  // Ready looks only at registered occupancy, never at this cycle's pop, so a
  // full buffer refuses a sample even on an edge that frees a slot.
  assign o_READY  = i_RESET_N && !fifo_full;
  assign push_vld = i_VALID && o_READY;

  acc_feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_CLK),
    .rst_n    (i_RESET_N),
    .flush    (i_CLEAR),
    .push_vld (push_vld),
    .push_dat (i_DATA_IN),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (level),
    .full     (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (i_CLEAR) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:  if (last_pop) state_d = ST_GAP;
        ST_GAP:  state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: outputs (pop request and frame completion)
  // ---------------------------------------------------------------------------
  always_comb begin
    pop      = 1'b0;
    gap_done = 1'b0;
    unique case (state_q)
      ST_RUN:  pop = (level != '0) && !i_HOLD && !i_CLEAR;
      // GAP ignores i_HOLD; only a clear can cancel the frame completion.
      ST_GAP:  gap_done = !i_CLEAR;
      default: begin
        pop      = 1'b0;
        gap_done = 1'b0;
      end
    endcase
  end

  assign last_pop = pop && (beat_q == LAST_BEAT);

  // Beat position within the current frame.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      beat_q <= '0;
    end else if (i_CLEAR) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= last_pop ? '0 : beat_q + 1'b1;
    end
  end

  // Accumulator drive: data holds its last value when not enabled so the
  // accumulator input never toggles on idle cycles.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      enable_q <= 1'b0;
      data_q   <= '0;
    end else begin
      enable_q <= pop;
      if (pop) begin
        data_q <= head_dat;
      end
    end
  end

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= gap_done;
      if (gap_done) begin
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  assign o_ENABLE      = enable_q;
  assign o_DATA_OUT    = data_q;
  assign o_FRAME_DONE  = frame_done_q;
  assign o_FRAME_COUNT = frame_count_q;
  assign o_FIFO_LEVEL  = level;

endmodule

// File: tb/tb_acc_frame_feeder.sv
// Directed bench for acc_frame_feeder with FRAME_LEN = 4, FIFO_DEPTH = 4.
// Inputs change 1 time unit after each rising edge; outputs are compared at that same point.
module tb_acc_frame_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int LW    = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          valid  = 1'b0;
  logic          hold   = 1'b0;
  logic          clear  = 1'b0;
  logic [DW-1:0] din    = '0;
  logic          ready;
  logic          en;
  logic [DW-1:0] dout;
  logic          done;
  logic [15:0]   cnt;
  logic [LW-1:0] lvl;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Hand-derived per-edge expectations for continuous push (values 20,21,...).
  int t3_lvl[11] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};
  int t3_en [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int t3_dat[11] = '{14, 20, 21, 22, 23, 23, 24, 25, 26, 27, 27};
  int t3_dn [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  acc_frame_feeder #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FLEN)
  ) dut (
    .i_CLK         (clk),
    .i_RESET_N     (rst_n),
    .i_VALID       (valid),
    .o_READY       (ready),
    .i_DATA_IN     (din),
    .i_HOLD        (hold),
    .i_CLEAR       (clear),
    .o_ENABLE      (en),
    .o_DATA_OUT    (dout),
    .o_FRAME_DONE  (done),
    .o_FRAME_COUNT (cnt),
    .o_FIFO_LEVEL  (lvl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame from an empty buffer in RUN at beat 0.
  task automatic run_frame(input string tag, input logic [31:0] base, input logic [15:0] exp_cnt);
    valid = 1'b1;
    din   = base;
    tick();
    chk({tag, ".first_en"}, en, 0);
    chk({tag, ".first_lvl"}, lvl, 1);
    for (int i = 1; i < 4; i++) begin
      din = base + i;
      tick();
      chk({tag, ".en"}, en, 1);
      chk({tag, ".dat"}, dout, base + i - 1);
      chk({tag, ".lvl"}, lvl, 1);
    end
    valid = 1'b0;
    tick();
    chk({tag, ".last_en"}, en, 1);
    chk({tag, ".last_dat"}, dout, base + 3);
    chk({tag, ".last_done"}, done, 0);
    chk({tag, ".last_lvl"}, lvl, 0);
    tick();
    chk({tag, ".gap_en"}, en, 0);
    chk({tag, ".gap_done"}, done, 1);
    chk({tag, ".gap_cnt"}, cnt, exp_cnt);
    chk({tag, ".gap_dat"}, dout, base + 3);
    tick();
    chk({tag, ".post_done"}, done, 0);
    chk({tag, ".post_en"}, en, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    chk("rst.ready", ready, 0);
    chk("rst.en", en, 0);
    chk("rst.dout", dout, 0);
    chk("rst.done", done, 0);
    chk("rst.cnt", cnt, 0);
    chk("rst.lvl", lvl, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst.ready_after", ready, 1);
    tick();

    // Basic frame: 1,2,3,4.
    run_frame("f1", 1, 1);

    // Hold with 5 pushes: buffer fills at 4, fifth waits for hold release.
    hold  = 1'b1;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 10 + i;
      tick();
      chk("hold.lvl", lvl, i + 1);
      chk("hold.en", en, 0);
    end
    chk("hold.ready_full", ready, 0);
    din = 14;
    tick();
    chk("hold.lvl_full", lvl, 4);
    chk("hold.ready_still", ready, 0);
    hold = 1'b0;
    tick();
    chk("hold.rel_en", en, 1);
    chk("hold.rel_dat", dout, 10);
    chk("hold.rel_lvl", lvl, 3);
    chk("hold.rel_ready", ready, 1);
    tick();
    chk("hold.pp_dat", dout, 11);
    chk("hold.pp_lvl", lvl, 3);
    valid = 1'b0;
    tick();
    chk("hold.d12", dout, 12);
    tick();
    chk("hold.d13", dout, 13);
    tick();
    chk("hold.gap_en", en, 0);
    chk("hold.gap_done", done, 1);
    chk("hold.gap_cnt", cnt, 2);
    tick();
    chk("hold.d14", dout, 14);
    chk("hold.d14_lvl", lvl, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("hold.clr_done", done, 0);
    chk("hold.clr_cnt", cnt, 2);

    // Continuous push: level steps up only in GAP cycles.
    for (int i = 0; i < 11; i++) begin
      valid = 1'b1;
      din   = 20 + i;
      tick();
      chk("cont.lvl", lvl, t3_lvl[i]);
      chk("cont.en", en, t3_en[i]);
      chk("cont.dat", dout, t3_dat[i]);
      chk("cont.done", done, t3_dn[i]);
    end
    chk("cont.cnt", cnt, 4);
    // Clear with a simultaneous push: push is ignored.
    din   = 99;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    valid = 1'b0;
    chk("cont.clr_lvl", lvl, 0);
    chk("cont.clr_en", en, 0);
    chk("cont.clr_cnt", cnt, 4);
    tick();
    chk("cont.clr_lvl2", lvl, 0);
    chk("cont.clr_en2", en, 0);

    // Clear after 2 of 4 beats: partial frame dropped, next frame complete.
    valid = 1'b1;
    din   = 40;
    tick();
    din = 41;
    tick();
    chk("part.d40", dout, 40);
    valid = 1'b0;
    tick();
    chk("part.d41", dout, 41);
    chk("part.lvl", lvl, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("part.clr_en", en, 0);
    chk("part.clr_done", done, 0);
    tick();
    chk("part.no_done", done, 0);
    chk("part.cnt", cnt, 4);
    run_frame("part_next", 42, 5);

    // Clear during GAP cancels that frame's completion.
    valid = 1'b1;
    din   = 50;
    tick();
    for (int i = 1; i < 4; i++) begin
      din = 50 + i;
      tick();
    end
    valid = 1'b0;
    tick();
    chk("gclr.last_dat", dout, 53);
    chk("gclr.last_en", en, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("gclr.done", done, 0);
    chk("gclr.cnt", cnt, 5);
    tick();
    chk("gclr.done2", done, 0);
    chk("gclr.cnt2", cnt, 5);
    run_frame("gclr_next", 54, 6);

    // Counter wrap from 0xFFFF.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    chk("wrap.pre", cnt, 16'hFFFF);
    run_frame("wrap", 60, 16'h0000);

    // Reset mid-frame, off the clock edge.
    valid = 1'b1;
    din   = 70;
    tick();
    din = 71;
    tick();
    chk("mrst.pre_en", en, 1);
    chk("mrst.pre_dat", dout, 70);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("mrst.ready", ready, 0);
    chk("mrst.en", en, 0);
    chk("mrst.dout", dout, 0);
    chk("mrst.lvl", lvl, 0);
    chk("mrst.done", done, 0);
    tick();
    tick();
    chk("mrst.held_lvl", lvl, 0);
    chk("mrst.held_ready", ready, 0);
    rst_n = 1'b1;
    run_frame("mrst_next", 80, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_frame_feeder.md
ACC_FRAME_FEEDER -- requirements
Module: acc_frame_feeder

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
 DATA_W  32  sample and output data width
 FIFO_DEPTH  4  input buffer entries, power of two, at least 2
 FRAME_LEN  8  samples per frame, at least 1
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
 i_CLK  in  1  single clock, all logic on its rising edge
 i_RESET_N  in  1  asynchronous active-low reset
 i_VALID  in  1  upstream sample valid
 o_READY  out  1  buffer can accept a sample
 i_DATA_IN  in  DATA_W  upstream sample
 i_HOLD  in  1  downstream stall; no sample is issued while high
 i_CLEAR  in  1  synchronous flush of buffer and partial frame
 o_ENABLE  out  1  drives accumulator i_ENABLE
 o_DATA_OUT  out  DATA_W  drives accumulator i_DATA_IN
 o_FRAME_DONE  out  1  one-cycle pulse after the last sample of a frame
 o_FRAME_COUNT  out  16  completed frames, wrapping
 o_FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  buffered sample count

Function
REQ-003 A sample SHALL be accepted on any rising edge where i_VALID and o_READY are both high.
REQ-004 o_READY SHALL equal (level < FIFO_DEPTH) and i_RESET_N; it SHALL NOT depend combinationally on i_HOLD, i_VALID or any same-cycle pop.
REQ-005 States SHALL be RUN and GAP; in RUN a pop SHALL occur on an edge where level > 0, i_HOLD = 0 and i_CLEAR = 0.
REQ-006 o_ENABLE and o_DATA_OUT SHALL be registered: after a popping edge o_ENABLE = 1 and o_DATA_OUT = popped word for one cycle; after any non-popping edge o_ENABLE = 0 and o_DATA_OUT holds its previous value.
REQ-007 Minimum latency SHALL be 2 edges: a sample accepted into an empty buffer at edge k SHALL be presented with o_ENABLE = 1 in the cycle after edge k+1.
REQ-008 A beat counter (0..FRAME_LEN-1) SHALL increment on each pop; the pop at beat FRAME_LEN-1 SHALL reset it to 0 and move the state to GAP.
REQ-009 GAP SHALL last exactly one cycle, pop nothing regardless of i_HOLD, and return to RUN; the edge leaving GAP SHALL set o_FRAME_DONE = 1 for one cycle and increment o_FRAME_COUNT, so o_FRAME_DONE coincides with the o_ENABLE = 0 cycle that follows the final sample.
REQ-010 o_FRAME_COUNT SHALL wrap 0xFFFF -> 0x0000.
REQ-011 A simultaneous push and pop SHALL both succeed with level unchanged; a push while full SHALL be impossible because o_READY = 0, even if a pop occurs on the same edge.
REQ-012 i_CLEAR high at an edge SHALL empty the buffer, zero the beat counter, force state RUN, drive o_ENABLE = 0 and ignore any simultaneous push; a partial frame SHALL be discarded without o_FRAME_DONE, and o_FRAME_COUNT SHALL be unchanged.
REQ-013 i_CLEAR during GAP SHALL cancel that GAP's o_FRAME_DONE and count increment.
REQ-014 Data SHALL pass unmodified in FIFO order, with no width change.

Reset
REQ-015 While i_RESET_N = 0, all state SHALL be held: level 0, beat 0, state RUN, o_ENABLE 0, o_DATA_OUT 0, o_FRAME_DONE 0, o_FRAME_COUNT 0, o_READY 0.
REQ-016 Reset asserted mid-frame SHALL discard buffered samples and the partial frame immediately; operation SHALL resume on the first edge after deassertion.

Structure
REQ-017 Package acc_feeder_pkg SHALL hold the DATA_W default, the FIFO_DEPTH default, the FRAME_COUNT width (16) and the RUN/GAP state type.
REQ-018 Buffering SHALL be one sub-module, acc_feeder_fifo (synchronous, first-word registered read, level output, flush input); the frame FSM SHALL live in acc_frame_feeder.

Verification
REQ-019 FRAME_LEN = 4; push 1,2,3,4 on consecutive cycles with i_HOLD = 0 -> o_ENABLE high 4 cycles with o_DATA_OUT 1,2,3,4, first beat 2 edges after first acceptance; o_FRAME_DONE pulses in the next cycle; o_FRAME_COUNT = 1.
REQ-020 Hold i_HOLD = 1 and push 5 samples, FIFO_DEPTH = 4 -> o_READY drops after 4 accepts, o_FIFO_LEVEL = 4, fifth sample is not taken until i_HOLD falls.
REQ-021 Continuous push with i_HOLD = 0 -> o_FIFO_LEVEL stays constant under simultaneous push/pop; exactly one o_ENABLE = 0 cycle per frame, carrying o_FRAME_DONE.
REQ-022 Assert i_CLEAR after 2 of 4 beats -> level 0, no o_FRAME_DONE, o_FRAME_COUNT unchanged; the next 4 samples form a complete frame.
REQ-023 Preload o_FRAME_COUNT to 0xFFFF and complete a frame -> o_FRAME_COUNT = 0x0000.
REQ-024 Drop i_RESET_N mid-frame off the clock edge -> outputs zero and o_READY = 0 immediately; after release, a full frame of 4 behaves as in REQ-019.
